// File: rtl/fetch.sv
// Instruction fetch stage: owns the fetch PC, keeps one imem read in flight and
// feeds {pc, predicted next pc, inst} to Decode. FETCH_STATIC_PREDICT_EN enables JAL/backward-branch prediction.
module fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        fetch_stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] fetch_pc,
   output logic [31:0] fetch_pred_next_pc,
   output logic [31:0] fetch_inst,
   output logic        fetch_valid
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] WAIT  = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   logic [1:0]  state;
   logic [31:0] fetch_addr;
   logic        pend_valid;
   logic [31:0] pend_pc;
   logic [31:0] pend_pred;
   logic [31:0] pend_inst;
   logic        req_fire;
   logic        resp_live;
   logic [31:0] resp_pred;
   logic [31:0] redirect_addr;

   // imem request handshake: a request transfers on any cycle where valid and ready are both high;
   // valid never depends on ready, and the address is stable while valid is held.
   assign imem_req_valid = !rst && (state == IDLE) && !fetch_stall && !redirect_valid && !pend_valid;
   assign imem_req_addr  = fetch_addr;
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign resp_live      = (state == WAIT) && imem_resp_valid;
   assign redirect_addr  = {redirect_pc[31:2], 2'b00};

`ifdef FETCH_STATIC_PREDICT_EN
   function automatic logic [31:0] predict(input logic [31:0] pc, input logic [31:0] inst);
      logic [31:0] j_imm;
      logic [31:0] b_imm;
      j_imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      b_imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      if (inst[6:0] == 7'b1101111)
         predict = pc + j_imm;
      else if ((inst[6:0] == 7'b1100011) && inst[31])
         predict = pc + b_imm;
      else
         predict = pc + 32'd4;
   endfunction

   assign resp_pred = predict(fetch_addr, imem_resp_data);
`else
   assign resp_pred = fetch_addr + 32'd4;
`endif

   // fetch_addr is the pc of the in-flight request until its response returns
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         fetch_addr <= RESET_PC;
      end else begin
         case (state)
            IDLE:    if (req_fire) state <= WAIT;
            WAIT: begin
               if (imem_resp_valid)     state <= IDLE;
               else if (redirect_valid) state <= DRAIN;
            end
            DRAIN:   if (imem_resp_valid) state <= IDLE;
            default: state <= IDLE;
         endcase
         if (redirect_valid)
            fetch_addr <= redirect_addr;
         else if (resp_live)
            fetch_addr <= resp_pred;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_valid         <= 1'b0;
         pend_pc            <= 32'd0;
         pend_pred          <= 32'd0;
         pend_inst          <= 32'd0;
         fetch_pc           <= 32'd0;
         fetch_pred_next_pc <= 32'd0;
         fetch_inst         <= NOP_INST;
         fetch_valid        <= 1'b0;
      end else if (redirect_valid) begin
         pend_valid  <= 1'b0;
         fetch_inst  <= NOP_INST;
         fetch_valid <= 1'b0;
      end else if (fetch_stall) begin
         if (resp_live) begin
            pend_valid <= 1'b1;
            pend_pc    <= fetch_addr;
            pend_pred  <= resp_pred;
            pend_inst  <= imem_resp_data;
         end
      end else if (pend_valid) begin
         pend_valid         <= 1'b0;
         fetch_pc           <= pend_pc;
         fetch_pred_next_pc <= pend_pred;
         fetch_inst         <= pend_inst;
         fetch_valid        <= 1'b1;
      end else if (resp_live) begin
         fetch_pc           <= fetch_addr;
         fetch_pred_next_pc <= resp_pred;
         fetch_inst         <= imem_resp_data;
         fetch_valid        <= 1'b1;
      end else begin
         fetch_inst  <= NOP_INST;
         fetch_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: a small instruction memory, a stream-level model of the fetched pc sequence,
// and directed phases covering reset, stall, redirect, prediction, wraparound and mid-flight reset.
module tb_fetch;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef FETCH_STATIC_PREDICT_EN
   localparam logic [31:0] JPRED = 32'h0000_00F8;
   localparam logic [31:0] BPRED = 32'h0000_003C;
`else
   localparam logic [31:0] JPRED = 32'h0000_0104;
   localparam logic [31:0] BPRED = 32'h0000_0044;
`endif

   logic        clk;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        fetch_stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] fetch_pc;
   logic [31:0] fetch_pred_next_pc;
   logic [31:0] fetch_inst;
   logic        fetch_valid;

   fetch #(.RESET_PC(RESET_PC), .NOP_INST(NOP)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .fetch_stall(fetch_stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .fetch_pc(fetch_pc), .fetch_pred_next_pc(fetch_pred_next_pc),
      .fetch_inst(fetch_inst), .fetch_valid(fetch_valid)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h want %08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      chk(name, {31'd0, act}, {31'd0, exp});
   endtask

   // instruction memory image, word indexed by addr[9:2]
   logic [31:0] mem_img [0:255];

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      return mem_img[a[9:2]];
   endfunction

   function automatic logic [31:0] model_pred(input logic [31:0] pc, input logic [31:0] inst);
`ifdef FETCH_STATIC_PREDICT_EN
      logic [20:0] j;
      logic [12:0] b;
      j = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      b = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      if (inst[6:0] == 7'b1101111) return pc + 32'($signed(j));
      if (inst[6:0] == 7'b1100011 && inst[31]) return pc + 32'($signed(b));
`else
      logic [31:0] unused_inst;
      unused_inst = inst;
`endif
      return pc + 32'd4;
   endfunction

   // memory responder: answers an accepted request after mem_lat cycles, in order
   int          mem_lat;
   int          mem_cnt;
   logic        mem_busy;
   logic [31:0] mem_a;

   initial begin
      logic        acc;
      logic [31:0] acc_a;
      int          acc_lat;
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'd0;
      mem_busy = 1'b0;
      mem_cnt  = 0;
      mem_a    = 32'd0;
      forever begin
         @(negedge clk);
         acc     = !rst && imem_req_valid && imem_req_ready;
         acc_a   = imem_req_addr;
         acc_lat = mem_lat;
         @(posedge clk);
         #1;
         imem_resp_valid = 1'b0;
         imem_resp_data  = 32'd0;
         if (mem_busy) mem_cnt--;
         if (acc) begin
            mem_busy = 1'b1;
            mem_cnt  = acc_lat;
            mem_a    = acc_a;
         end
         if (mem_busy && mem_cnt <= 1) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_rd(mem_a);
            mem_busy = 1'b0;
         end
      end
   end

   // scoreboard: pcs of live requests, in the order they must be presented
   logic [31:0] exp_q[$];
   logic [31:0] exp_req_pc;
   logic        live_out;
   logic        prev_ok, prev_stall, prev_redirect, prev_valid;
   logic [31:0] prev_pc, prev_pred, prev_inst;

   initial begin
      logic [31:0] p;
      prev_ok = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("rst_fetch_pc", fetch_pc, 32'd0);
            chk("rst_pred", fetch_pred_next_pc, 32'd0);
            chk("rst_inst", fetch_inst, NOP);
            chk1("rst_valid", fetch_valid, 1'b0);
            chk1("rst_req_valid", imem_req_valid, 1'b0);
            exp_q.delete();
            exp_req_pc = RESET_PC;
            live_out   = 1'b0;
            prev_ok    = 1'b0;
         end else begin
            if (!fetch_valid) chk("bubble_inst", fetch_inst, NOP);
            if (prev_ok && prev_stall && !prev_redirect) begin
               chk("hold_pc", fetch_pc, prev_pc);
               chk("hold_pred", fetch_pred_next_pc, prev_pred);
               chk("hold_inst", fetch_inst, prev_inst);
               chk1("hold_valid", fetch_valid, prev_valid);
            end else if (prev_ok && prev_redirect) begin
               chk1("redirect_bubble", fetch_valid, 1'b0);
            end else if (fetch_valid) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_inst: got pc %08h want none (t=%0t)", fetch_pc, $time);
               end else begin
                  p = exp_q.pop_front();
                  chk("pres_pc", fetch_pc, p);
                  chk("pres_inst", fetch_inst, mem_rd(p));
                  chk("pres_pred", fetch_pred_next_pc, model_pred(p, mem_rd(p)));
               end
            end
            if (imem_req_valid) begin
               chk1("req_legal", !(fetch_stall || redirect_valid || live_out), 1'b1);
               if (imem_req_ready) chk("req_addr", imem_req_addr, exp_req_pc);
            end
            if (imem_resp_valid) live_out = 1'b0;
            if (imem_req_valid && imem_req_ready) begin
               exp_q.push_back(exp_req_pc);
               exp_req_pc = model_pred(exp_req_pc, mem_rd(exp_req_pc));
               live_out   = 1'b1;
            end
            if (redirect_valid) begin
               exp_q.delete();
               exp_req_pc = {redirect_pc[31:2], 2'b00};
            end
            prev_ok       = 1'b1;
            prev_stall    = fetch_stall;
            prev_redirect = redirect_valid;
            prev_valid    = fetch_valid;
            prev_pc       = fetch_pc;
            prev_pred     = fetch_pred_next_pc;
            prev_inst     = fetch_inst;
         end
      end
   end

   // driver tasks
   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) next();
      rst = 1'b0;
   endtask

   initial begin
      logic [63:0] stall_pat;
      logic [63:0] ready_pat;
      logic [63:0] lat_pat;
      stall_pat = 64'h0C30_0600_00E0_1800;
      ready_pat = 64'hFFF7_BDEF_F7DF_FEFB;
      lat_pat   = 64'h00FF_00F0_F0F0_0F00;
      for (int i = 0; i < 256; i++) mem_img[i] = NOP | (32'(i) << 20);
      mem_img[0]  = 32'h0050_0093;
      mem_img[1]  = 32'h00A0_0113;
      mem_img[16] = 32'hFE00_0EE3;
      mem_img[64] = 32'hFF9F_F06F;
      rst = 1'b1;
      fetch_stall = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = 32'd0;
      imem_req_ready = 1'b1;
      mem_lat = 1;
      repeat (2) mid();

      // basic fetch with 1-cycle memory, then stall across a response
      next(); rst = 1'b0;
      mid();
      chk1("c0_req_valid", imem_req_valid, 1'b1);
      chk("c0_req_addr", imem_req_addr, 32'h0);
      next(); mid();
      chk1("c1_valid", fetch_valid, 1'b0);
      chk1("c1_req_valid", imem_req_valid, 1'b0);
      next(); mid();
      chk1("c2_valid", fetch_valid, 1'b1);
      chk("c2_pc", fetch_pc, 32'h0);
      chk("c2_pred", fetch_pred_next_pc, 32'h4);
      chk("c2_inst", fetch_inst, 32'h0050_0093);
      chk("c2_req_addr", imem_req_addr, 32'h4);
      next(); fetch_stall = 1'b1; mid();
      chk1("c3_valid", fetch_valid, 1'b0);
      chk("c3_inst", fetch_inst, NOP);
      chk("c3_pc_hold", fetch_pc, 32'h0);
      next(); mid();
      chk1("c4_req_valid", imem_req_valid, 1'b0);
      next(); mid();
      chk1("c5_valid", fetch_valid, 1'b0);
      next(); fetch_stall = 1'b0; mid();
      chk1("c6_req_valid", imem_req_valid, 1'b0);
      next(); mid();
      chk1("c7_valid", fetch_valid, 1'b1);
      chk("c7_pc", fetch_pc, 32'h4);
      chk("c7_inst", fetch_inst, 32'h00A0_0113);
      chk("c7_req_addr", imem_req_addr, 32'h8);
      next(); mid();
      chk1("c8_valid", fetch_valid, 1'b0);

      // redirect while waiting, response 2 cycles later is dropped
      next(); mem_lat = 3; do_reset();
      mid();
      chk("r0_req_addr", imem_req_addr, 32'h0);
      next(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0203; mid();
      chk1("r1_req_valid", imem_req_valid, 1'b0);
      next(); redirect_valid = 1'b0; mid();
      chk1("r2_valid", fetch_valid, 1'b0);
      next(); mid();
      chk1("r3_req_valid", imem_req_valid, 1'b0);
      next(); mem_lat = 1; mid();
      chk1("r4_valid", fetch_valid, 1'b0);
      chk1("r4_req_valid", imem_req_valid, 1'b1);
      chk("r4_req_addr", imem_req_addr, 32'h200);
      next(); mid();
      next(); mid();
      chk("r6_pc", fetch_pc, 32'h200);
      chk("r6_inst", fetch_inst, 32'h0800_0013);

      // redirect as a response lands, then JAL prediction
      next(); redirect_valid = 1'b1; redirect_pc = 32'h100; mid();
      chk1("j7_req_valid", imem_req_valid, 1'b0);
      next(); redirect_valid = 1'b0; mid();
      chk1("j8_valid", fetch_valid, 1'b0);
      chk("j8_req_addr", imem_req_addr, 32'h100);
      next(); mid();
      next(); mid();
      chk("j10_pc", fetch_pc, 32'h100);
      chk("j10_inst", fetch_inst, 32'hFF9F_F06F);
      chk("j10_pred", fetch_pred_next_pc, JPRED);
      chk("j10_req_addr", imem_req_addr, JPRED);

      // backward and forward conditional branch
      next(); mid();
      next(); redirect_valid = 1'b1; redirect_pc = 32'h40; mid();
      chk1("b12_req_valid", imem_req_valid, 1'b0);
      next(); redirect_valid = 1'b0; mid();
      next(); mid();
      next(); mid();
      chk("b15_pc", fetch_pc, 32'h40);
      chk("b15_pred", fetch_pred_next_pc, BPRED);
      next(); mem_img[16] = 32'h0000_0463; redirect_valid = 1'b1; redirect_pc = 32'h42; mid();
      next(); redirect_valid = 1'b0; mid();
      chk("b17_req_addr", imem_req_addr, 32'h40);
      next(); mid();
      next(); mid();
      chk("b19_inst", fetch_inst, 32'h0000_0463);
      chk("b19_pred", fetch_pred_next_pc, 32'h44);

      // pc wraparound
      next(); mid();
      next(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF; mid();
      next(); redirect_valid = 1'b0; mid();
      chk("w22_req_addr", imem_req_addr, 32'hFFFF_FFFC);
      next(); mid();
      next(); mem_lat = 3; mid();
      chk("w24_pc", fetch_pc, 32'hFFFF_FFFC);
      chk("w24_pred", fetch_pred_next_pc, 32'h0);
      chk("w24_req_addr", imem_req_addr, 32'h0);

      // reset while a request is in flight; stale response must be ignored
      next(); rst = 1'b1; mid();
      chk1("x25_valid", fetch_valid, 1'b0);
      chk("x25_pc", fetch_pc, 32'h0);
      next(); rst = 1'b0; imem_req_ready = 1'b0; mid();
      chk("x26_req_addr", imem_req_addr, RESET_PC);
      next(); mid();
      next(); mid();
      chk1("x28_valid", fetch_valid, 1'b0);
      chk1("x28_req_valid", imem_req_valid, 1'b1);
      next(); imem_req_ready = 1'b1; mem_lat = 1; mid();
      next(); mid();
      next(); mid();
      chk("x31_pc", fetch_pc, 32'h0);
      chk("x31_inst", fetch_inst, 32'h0050_0093);

      // mixed stall / ready / latency / redirect table, checked by the scoreboard
      for (int i = 0; i < 64; i++) begin
         next();
         fetch_stall    = stall_pat[i];
         imem_req_ready = ready_pat[i];
         mem_lat        = lat_pat[i] ? 2 : 1;
         redirect_valid = (i == 20) || (i == 45) || (i == 46);
         redirect_pc    = (i < 40) ? 32'h81 : 32'h3FE;
      end
      next();
      fetch_stall = 1'b0;
      redirect_valid = 1'b0;
      imem_req_ready = 1'b0;
      repeat (8) next();
      chk("drain_empty", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fetch.md
Name: fetch

Overview:
- Instruction fetch stage. Owns the architectural fetch PC and issues one instruction-memory read at a time.
- Presents {pc, predicted next pc, instruction} to Decode on the fetch_* interface. Decode flops this interface every cycle with no valid input, so fetch inserts NOP bubbles whenever it has no new instruction.
- Accepts redirects from Execute on mispredict.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INST, 32'h0000_0013, bubble encoding (addi x0,x0,0).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- imem_req_valid  out  1  read request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  word-aligned read address
- imem_resp_valid  in  1  read data valid, in order, at least 1 cycle after acceptance
- imem_resp_data  in  32  instruction word
- fetch_stall  in  1  hazard hold from Decode/Execute
- redirect_valid  in  1  Execute mispredict/flush
- redirect_pc  in  32  corrected pc; bits[1:0] ignored (forced to 0)
- fetch_pc  out  32  pc of presented instruction
- fetch_pred_next_pc  out  32  predicted successor pc
- fetch_inst  out  32  instruction, or NOP_INST when bubble
- fetch_valid  out  1  1 = real instruction, 0 = bubble

Behaviour:
- Interface: one clock, clk; reset asynchronous active-high, rst.
- Reset values:
  - state=IDLE, fetch_addr=RESET_PC, pending buffer empty.
  - fetch_pc=0, fetch_pred_next_pc=0, fetch_inst=NOP_INST, fetch_valid=0, imem_req_valid=0.
- Single outstanding request. States:
  - IDLE: no request in flight.
  - WAIT: live request in flight.
  - DRAIN: squashed request in flight; its response is dropped.
- IDLE:
  - imem_req_valid=1 and imem_req_addr=fetch_addr when fetch_stall=0, redirect_valid=0 and pending empty; otherwise 0.
  - req_valid&req_ready -> WAIT.
- WAIT: on imem_resp_valid -> IDLE.
  - Response goes to the output register if fetch_stall=0.
  - Response goes to the pending buffer if fetch_stall=1.
  - fetch_addr <= predicted next pc of that instruction.
- DRAIN: on imem_resp_valid, response discarded -> IDLE.
- Prediction: pred = pc+4 (see Optional Feature).
- Output register, fetch_stall=0, first match wins:
  - pending buffer (then clear it);
  - live WAIT response;
  - otherwise bubble (fetch_valid=0, fetch_inst=NOP_INST; fetch_pc/pred hold).
  - A valid instruction is never presented for 2 consecutive cycles.
- Output register, fetch_stall=1: all fetch_* hold.
- Redirect has highest priority, regardless of stall:
  - fetch_addr <= {redirect_pc[31:2],2'b00}; pending cleared; next cycle fetch_valid=0, fetch_inst=NOP_INST.
  - IDLE: stays IDLE, and no request is issued that cycle.
  - WAIT with no response this cycle: -> DRAIN.
  - WAIT with a response this cycle: response dropped -> IDLE.
  - DRAIN: stays DRAIN, unless resp_valid that cycle -> IDLE.
  - A request cannot be accepted in a redirect cycle, because req_valid=0.
- Throughput: one instruction per 2 cycles with single-cycle memory.
- Arithmetic: 32-bit, wraps modulo 2^32 (pc 0xFFFF_FFFC + 4 = 0).
- Reset mid-operation: returns to reset values; any in-flight response after deassertion is ignored (state IDLE).

Optional Feature:
- Macro: FETCH_STATIC_PREDICT_EN.
- Defined:
  - JAL (opcode 1101111): pred = pc + J-immediate.
  - Conditional branch (opcode 1100011) with imm[12]=1 (backward): pred = pc + B-immediate.
  - All other instructions: pc+4.
  - Next fetch_addr follows pred.
- Undefined: pred always pc+4; no immediate decode logic.

Test Plan:
- Reset, 1-cycle memory, addr 0 returns 0x00500093 -> req addr 0; then fetch_valid=1, fetch_pc=0, fetch_pred_next_pc=4, fetch_inst=0x00500093; next req addr 4; bubble cycles show fetch_inst=0x00000013, fetch_valid=0.
- fetch_stall=1 while response 0x00A00113 arrives -> outputs unchanged during stall, no new request; stall drops -> 0x00A00113 presented exactly once, then bubble.
- Redirect to 0x0000_0203 while WAIT, response arrives 2 cycles later -> response dropped, fetch_valid=0, next req addr 0x0000_0200.
- FETCH_STATIC_PREDICT_EN, pc 0x100, inst 0xFF9FF06F (jal x0,-8) -> pred 0xF8, next req 0xF8; macro undefined -> pred 0x104.
- FETCH_STATIC_PREDICT_EN, pc 0x40, inst 0xFE000EE3 (beq x0,x0,-4) -> pred 0x3C; forward branch 0x00000463 -> pred 0x44.
- rst asserted mid-WAIT -> outputs to reset values immediately; after release, req addr = RESET_PC; stale response ignored.
